seq_pattern_detector: RTL and testbench
=======================================

// Module: seq_pattern_detector
// PURPOSE
//  Parametrised, programmable serial sequence detector; successor to the fixed 4-state Moore "101" detector FSM.
//  Watches a 1-bit serial stream and detects a run-time programmable N-bit pattern.
//  Supports overlapping / non-overlapping match modes and input qualification.
//  Provides a registered (Moore) match pulse plus a saturating match counter.
//  Sits between a serial front-end and control logic that consumes match events.
// PARAMETERS
//  N            4         pattern length in bits; legal range 2..32
//  CNT_W        8         width of match_count
//  PATTERN_RST  4'b1011   pattern value loaded at reset; N bits, MSB is the first bit received
//  OVERLAP_RST  1'b1      overlap mode loaded at reset
// PORTS
//  clk          in   1          single clock; all state updates on posedge
//  reset        in   1          synchronous, active-high
//  cfg_load     in   1          load cfg_pattern/cfg_overlap; clear stream state
//  cfg_pattern  in   N          new pattern; bit N-1 is the first bit of the sequence
//  cfg_overlap  in   1          1 = overlapping matches, 0 = restart after each match
//  in_valid     in   1          in is sampled only when high
//  in           in   1          serial data bit
//  match        out  1          high for exactly one cycle after the bit completing a match
//  match_count  out  CNT_W      number of matches since reset/cfg_load; saturates
//  fill         out  clog2(N+1) consecutive history bits held (0..N); progress indicator
// BEHAVIOUR
//  Reset values (reset high at posedge):
//   - hist=0, fill=0, match=0, match_count=0
//   - pattern=PATTERN_RST, overlap=OVERLAP_RST
//  Priority: reset > cfg_load > in_valid.
//  cfg_load cycle:
//   - pattern/overlap <= cfg inputs; hist=0, fill=0, match=0, match_count=0
//   - in is ignored even if in_valid=1
//  in_valid=1 (no reset, no cfg_load):
//   - hist_n = {hist[N-2:0], in}; fill_n = min(fill+1, N)
//   - hit = (fill_n==N) && (hist_n==pattern)
//   - match <= hit (latency 1: visible the cycle after the completing bit is sampled)
//   - hit: match_count <= match_count+1, holding at 2^CNT_W-1 once reached
//   - hit && !overlap: fill <= 0; next match needs N fresh bits
//   - hit && overlap: fill stays N; bits shared with the previous match count again
//  in_valid=0: hist, fill and match_count hold; match <= 0.
//  match is never high two cycles in a row unless in_valid is high on both accepting edges.
//  fill never exceeds N; a mismatch does not reduce fill (history-window compare, no fallback table).
// STRUCTURE
//  Package seqdet_pkg holds:
//   - localparam function cnt_max(CNT_W)
//   - FILL_W = $clog2(N+1) helper
//   - default pattern constant
//  Sub-module sat_counter #(W): inputs clr/inc, saturating output; used for match_count.
//  Top level holds: pattern/overlap config regs, hist shift reg, fill counter, match reg.
// TESTING
//  1. Pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 (in_valid=1 throughout)
//     -> match pulses after bits 4 and 7; match_count=2.
//  2. Same stream, cfg_overlap=0 via cfg_load
//     -> match after bit 4 only; fill=3 at end; match_count=1.
//  3. Test 1 with 2 idle cycles (in_valid=0) between each bit
//     -> same 2 matches; match low on idle cycles; fill holds during gaps.
//  4. CNT_W=2, N=2, pattern 11, overlap=1, six 1s
//     -> match high on 5 consecutive cycles; match_count stops at 3.
//  5. After bits 1,0,1: cfg_load pattern 0110 with in_valid=1, in=1 on the same cycle
//     -> fill=0, match_count=0, that bit dropped; stream 0,1,1,0 then matches once.
//  6. Reset asserted with fill=3 and match_count=5, cfg_load also high
//     -> next cycle all outputs 0 and pattern=PATTERN_RST.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared definitions for the programmable serial sequence detector.
//   DEFAULT_PATTERN : pattern loaded at reset when the top is left at N=4
//   overlap_e       : match-mode encoding held in the config register
//   cnt_max()       : all-ones value of a W-bit saturating counter
//   fill_w()        : width needed to hold a fill level of 0..N
package seqdet_pkg;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    typedef enum logic {
        MODE_RESTART = 1'b0,
        MODE_OVERLAP = 1'b1
    } overlap_e;

    function automatic logic [63:0] cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic int unsigned fill_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   reset : synchronous active-high clear
//   clr   : synchronous clear (same effect as reset)
//   inc   : increment request; ignored once the counter is all ones
//   count : current value
module sat_counter
    import seqdet_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(cnt_max(W));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial sequence detector with a history-window compare.
//   clk, reset  : clock, synchronous active-high reset
//   cfg_load    : load cfg_pattern/cfg_overlap and clear stream state
//   cfg_pattern : pattern, bit N-1 is the first bit received
//   cfg_overlap : 1 = overlapping matches, 0 = restart after a match
//   in_valid/in : qualified serial data bit
//   match       : one-cycle registered pulse after the completing bit
//   match_count : saturating match count since reset/cfg_load
//   fill        : consecutive history bits held (0..N)
module seq_pattern_detector
    import seqdet_pkg::*;
#(
    parameter int unsigned   N           = 4,
    parameter int unsigned   CNT_W       = 8,
    parameter logic [N-1:0]  PATTERN_RST = DEFAULT_PATTERN,
    parameter logic          OVERLAP_RST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_load,
    input  logic [N-1:0]           cfg_pattern,
    input  logic                   cfg_overlap,
    input  logic                   in_valid,
    input  logic                   in,
    output logic                   match,
    output logic [CNT_W-1:0]       match_count,
    output logic [fill_w(N)-1:0]   fill
);

    localparam int unsigned FILL_W = fill_w(N);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    logic [N-1:0]      pattern_q;
    overlap_e          overlap_q;
    logic [N-1:0]      hist_q;
    logic [FILL_W-1:0] fill_q;
    logic              match_q;

    logic [N-1:0]      hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              hit;

    always_comb begin
        hist_n = {hist_q[N-2:0], in};
        fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        // Only a full window can match; a mismatch never shrinks the window.
        hit    = in_valid && !cfg_load && (fill_n == FILL_FULL) && (hist_n == pattern_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= PATTERN_RST;
            overlap_q <= overlap_e'(OVERLAP_RST);
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            overlap_q <= overlap_e'(cfg_overlap);
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (in_valid) begin
            hist_q  <= hist_n;
            // Restart mode discards the window so the next match needs N fresh bits.
            fill_q  <= (hit && (overlap_q == MODE_RESTART)) ? '0 : fill_n;
            match_q <= hit;
        end else begin
            match_q <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .inc   (hit),
        .count (match_count)
    );

    assign match = match_q;
    assign fill  = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic [1:0] cfg_pattern2 = 2'b00;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;

    logic       match;
    logic [7:0] match_count;
    logic [2:0] fill;
    logic       match2;
    logic [1:0] match_count2;
    logic [1:0] fill2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_detector #(
        .N           (4),
        .CNT_W       (8),
        .PATTERN_RST (4'b1011),
        .OVERLAP_RST (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in_bit),
        .match       (match),
        .match_count (match_count),
        .fill        (fill)
    );

    seq_pattern_detector #(
        .N           (2),
        .CNT_W       (2),
        .PATTERN_RST (2'b11),
        .OVERLAP_RST (1'b1)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern2),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in_bit),
        .match       (match2),
        .match_count (match_count2),
        .fill        (fill2)
    );

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] pat, input logic ov);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ov;
        step(1'b0, 1'b0);
        cfg_load = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic m, input int cnt,
                                 input int f);
        check_eq({tag, "_match"}, 32'(match), 32'(m));
        check_eq({tag, "_count"}, 32'(match_count), 32'(cnt));
        check_eq({tag, "_fill"}, 32'(fill), 32'(f));
    endtask

    logic [6:0] stream_a = 7'b1011011;
    logic [6:0] exp_ov   = 7'b0001001;
    logic [6:0] exp_nov  = 7'b0001000;
    int         fill_ov[7]  = '{1, 2, 3, 4, 4, 4, 4};
    int         fill_nov[7] = '{1, 2, 3, 0, 1, 2, 3};
    int         cnt2[6]     = '{0, 1, 2, 3, 3, 3};

    initial begin
        // Reset state
        do_reset();
        check_outputs("rst", 1'b0, 0, 0);

        // 1: overlapping 1011 from reset configuration
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream_a[6-i]);
            check_eq($sformatf("t1_match_%0d", i), 32'(match), 32'(exp_ov[6-i]));
            check_eq($sformatf("t1_fill_%0d", i), 32'(fill), 32'(fill_ov[i]));
        end
        check_eq("t1_count", 32'(match_count), 32'd2);
        step(1'b0, 1'b0);
        check_eq("t1_match_after", 32'(match), 32'd0);

        // 2: non-overlapping
        load(4'b1011, 1'b0);
        check_outputs("t2_load", 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream_a[6-i]);
            check_eq($sformatf("t2_match_%0d", i), 32'(match), 32'(exp_nov[6-i]));
            check_eq($sformatf("t2_fill_%0d", i), 32'(fill), 32'(fill_nov[i]));
        end
        check_eq("t2_count", 32'(match_count), 32'd1);

        // 3: overlapping with two idle cycles after each bit
        load(4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream_a[6-i]);
            check_eq($sformatf("t3_match_%0d", i), 32'(match), 32'(exp_ov[6-i]));
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 1'b1);
                check_eq($sformatf("t3_idle_match_%0d_%0d", i, j), 32'(match), 32'd0);
                check_eq($sformatf("t3_idle_fill_%0d_%0d", i, j), 32'(fill),
                         32'(fill_ov[i]));
            end
        end
        check_eq("t3_count", 32'(match_count), 32'd2);

        // 5: cfg_load wins over a valid bit on the same cycle
        load(4'b1011, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("t5_pre_fill", 32'(fill), 32'd3);
        cfg_load    = 1'b1;
        cfg_pattern = 4'b0110;
        cfg_overlap = 1'b1;
        step(1'b1, 1'b1);
        cfg_load = 1'b0;
        check_outputs("t5_load", 1'b0, 0, 0);
        step(1'b1, 1'b0);
        check_outputs("t5_b0", 1'b0, 0, 1);
        step(1'b1, 1'b1);
        check_outputs("t5_b1", 1'b0, 0, 2);
        step(1'b1, 1'b1);
        check_outputs("t5_b2", 1'b0, 0, 3);
        step(1'b1, 1'b0);
        check_outputs("t5_b3", 1'b1, 1, 4);

        // 6: reset beats cfg_load, config returns to reset values
        load(4'b1111, 1'b0);
        for (int i = 0; i < 23; i++) step(1'b1, 1'b1);
        check_outputs("t6_pre", 1'b0, 5, 3);
        reset       = 1'b1;
        cfg_load    = 1'b1;
        cfg_pattern = 4'b0000;
        cfg_overlap = 1'b0;
        step(1'b1, 1'b1);
        reset    = 1'b0;
        cfg_load = 1'b0;
        check_outputs("t6_rst", 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream_a[6-i]);
            check_eq($sformatf("t6_match_%0d", i), 32'(match), 32'(exp_ov[6-i]));
        end
        check_eq("t6_count", 32'(match_count), 32'd2);

        // 4: N=2, CNT_W=2, pattern 11 overlapping, six 1s
        do_reset();
        check_eq("t4_rst_fill", 32'(fill2), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            check_eq($sformatf("t4_match_%0d", i), 32'(match2), (i == 0) ? 32'd0 : 32'd1);
            check_eq($sformatf("t4_count_%0d", i), 32'(match_count2), 32'(cnt2[i]));
        end
        check_eq("t4_fill", 32'(fill2), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
